// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register family: the MIPS nop
// word, the IF/ID payload layout, and the per-slice control operation.
package pipe_pkg;

    // MIPS "sll $0, $0, 0" encodes as all zeros and serves as the bubble
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    // Bit offsets of the two fields packed into the default 64-bit payload
    localparam int          INSTR_LSB = 0;
    localparam int          PC4_LSB   = 32;

    // Field view of the default IF/ID payload, matching the offsets above
    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] instruction;
    } ifid_payload_t;

    // What a single slice does at the next clock edge
    typedef enum logic [1:0] {
        SLICE_HOLD   = 2'd0,
        SLICE_LOAD   = 2'd1,
        SLICE_BUBBLE = 2'd2
    } slice_op_e;

endpackage

// File: rtl/pipe_slice.sv
// One valid+data register slice. The top decides per edge whether every
// slice loads its upstream neighbour, becomes a bubble, or holds.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                  clk,
    input  slice_op_e             i_op,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // Apply the requested operation; bubble also covers reset since reset is synchronous
    always_ff @(posedge clk) begin
        case (i_op)
            SLICE_BUBBLE: begin
                r_valid <= 1'b0;
                r_data  <= BUBBLE_VALUE;
            end
            SLICE_LOAD: begin
                r_valid <= i_valid;
                r_data  <= i_data;
            end
            default: begin
                r_valid <= r_valid;
                r_data  <= r_data;
            end
        endcase
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_register.sv
// Parametrised pipeline stage register: NUM_STAGES chained valid+data slices
// sharing one advance/flush control, with saturating stall and flush counters.
module pipe_stage_register
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    NUM_STAGES   = 1,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter bit                    ZERO_INVALID = 1'b1,
    parameter int                    CNT_WIDTH    = 16,
    localparam int                   OCC_WIDTH    = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    slice_op_e             w_op;
    logic [DATA_WIDTH-1:0] w_stage0Data;
    logic                  w_sliceValid   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] w_sliceData    [NUM_STAGES];
    logic                  w_sliceInValid [NUM_STAGES];
    logic [DATA_WIDTH-1:0] w_sliceInData  [NUM_STAGES];
    logic [OCC_WIDTH-1:0]  w_occupancy;
    logic [CNT_WIDTH-1:0]  r_stallCount;
    logic [CNT_WIDTH-1:0]  r_flushCount;

    // An invalid capture optionally stores the bubble so downstream sees a clean nop
    assign w_stage0Data = (!valid_in && ZERO_INVALID) ? BUBBLE_VALUE : data_in;

    // One shared operation for every slice: reset and flush both bubble, else advance or hold
    always_comb begin
        w_op = SLICE_HOLD;
        if (!reset || flush) begin
            w_op = SLICE_BUBBLE;
        end else if (enable) begin
            w_op = SLICE_LOAD;
        end
    end

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_slice
        if (gi == 0) begin : g_head
            assign w_sliceInValid[gi] = valid_in;
            assign w_sliceInData[gi]  = w_stage0Data;
        end else begin : g_body
            assign w_sliceInValid[gi] = w_sliceValid[gi-1];
            assign w_sliceInData[gi]  = w_sliceData[gi-1];
        end

        pipe_slice #(
            .DATA_WIDTH   (DATA_WIDTH),
            .BUBBLE_VALUE (BUBBLE_VALUE)
        ) u_slice (
            .clk     (clk),
            .i_op    (w_op),
            .i_valid (w_sliceInValid[gi]),
            .i_data  (w_sliceInData[gi]),
            .o_valid (w_sliceValid[gi]),
            .o_data  (w_sliceData[gi])
        );
    end

    // Population count of the slice valid bits
    always_comb begin
        w_occupancy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_occupancy = w_occupancy + OCC_WIDTH'(w_sliceValid[i]);
        end
    end

    // Saturating performance counters; a flush edge is never also counted as a stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else if (flush) begin
            if (r_flushCount != CNT_MAX) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end else if (!enable) begin
            if (r_stallCount != CNT_MAX) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
        end
    end

    assign valid_out   = w_sliceValid[NUM_STAGES-1];
    assign data_out    = w_sliceData[NUM_STAGES-1];
    assign occupancy   = w_occupancy;
    assign stall_count = r_stallCount;
    assign flush_count = r_flushCount;

endmodule

// File: tb/tb_pipe_stage_register.sv
// Self-checking bench: a 3-stage instance with bubble-on-invalid and a
// 1-stage instance with payload-on-invalid and 4-bit counters share stimulus.
// Both are compared each cycle against a queue-based delay-line model, plus
// hand-computed expectations for the directed sequences.
module tb_pipe_stage_register;

    localparam int NA   = 3;
    localparam int NB   = 1;
    localparam int MAXA = 65535;
    localparam int MAXB = 15;

    typedef struct packed {
        logic        v;
        logic [63:0] d;
    } entry_t;

    typedef struct {
        bit          r;
        bit          e;
        bit          f;
        bit          v;
        logic [63:0] d;
        bit          expValid;
        logic [63:0] expData;
        int          expOcc;
        int          expStall;
        int          expFlush;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        validIn;
    logic [63:0] dataIn;

    logic        validA;
    logic [63:0] dataA;
    logic [1:0]  occA;
    logic [15:0] stallA;
    logic [15:0] flushA;

    logic        validB;
    logic [63:0] dataB;
    logic [0:0]  occB;
    logic [3:0]  stallB;
    logic [3:0]  flushB;

    entry_t qA[$];
    entry_t qB[$];
    int     sA, fA, sB, fB;
    int     total;
    int     bad;
    rec_t   vec[17];

    pipe_stage_register #(
        .DATA_WIDTH   (64),
        .NUM_STAGES   (NA),
        .BUBBLE_VALUE (64'h0),
        .ZERO_INVALID (1'b1),
        .CNT_WIDTH    (16)
    ) dutA (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .valid_in    (validIn),
        .data_in     (dataIn),
        .valid_out   (validA),
        .data_out    (dataA),
        .occupancy   (occA),
        .stall_count (stallA),
        .flush_count (flushA)
    );

    pipe_stage_register #(
        .DATA_WIDTH   (64),
        .NUM_STAGES   (NB),
        .BUBBLE_VALUE (64'h0),
        .ZERO_INVALID (1'b0),
        .CNT_WIDTH    (4)
    ) dutB (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .valid_in    (validIn),
        .data_in     (dataIn),
        .valid_out   (validB),
        .data_out    (dataB),
        .occupancy   (occB),
        .stall_count (stallB),
        .flush_count (flushB)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Delay-line model: each instance is a queue, front = newest slice
    task automatic modelStep();
        entry_t bubble;
        entry_t inA;
        entry_t inB;
        bubble = '{v: 1'b0, d: 64'h0};
        inA    = '{v: validIn, d: validIn ? dataIn : 64'h0};
        inB    = '{v: validIn, d: dataIn};
        if (!reset) begin
            qA.delete();
            qB.delete();
            repeat (NA) qA.push_back(bubble);
            repeat (NB) qB.push_back(bubble);
            sA = 0; fA = 0; sB = 0; fB = 0;
        end else if (flush) begin
            foreach (qA[i]) qA[i] = bubble;
            foreach (qB[i]) qB[i] = bubble;
            if (fA < MAXA) fA++;
            if (fB < MAXB) fB++;
        end else if (enable) begin
            qA.push_front(inA);
            void'(qA.pop_back());
            qB.push_front(inB);
            void'(qB.pop_back());
        end else begin
            if (sA < MAXA) sA++;
            if (sB < MAXB) sB++;
        end
    endtask

    task automatic checkOutput();
        int oA;
        int oB;
        oA = 0;
        oB = 0;
        foreach (qA[i]) oA += int'(qA[i].v);
        foreach (qB[i]) oB += int'(qB[i].v);
        cmp("A.valid_out",   64'(validA), 64'(qA[NA-1].v));
        cmp("A.data_out",    dataA,       qA[NA-1].d);
        cmp("A.occupancy",   64'(occA),   64'(oA));
        cmp("A.stall_count", 64'(stallA), 64'(sA));
        cmp("A.flush_count", 64'(flushA), 64'(fA));
        cmp("B.valid_out",   64'(validB), 64'(qB[NB-1].v));
        cmp("B.data_out",    dataB,       qB[NB-1].d);
        cmp("B.occupancy",   64'(occB),   64'(oB));
        cmp("B.stall_count", 64'(stallB), 64'(sB));
        cmp("B.flush_count", 64'(flushB), 64'(fB));
    endtask

    // Drive on the falling edge, clock it in, then check just after the rising edge
    task automatic applyStimulus(input bit r, input bit e, input bit f, input bit v, input logic [63:0] d);
        @(negedge clk);
        reset   = r;
        enable  = e;
        flush   = f;
        validIn = v;
        dataIn  = d;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        validIn = 1'b0;
        dataIn  = '0;

        // r e f v data | valid_out data_out occupancy stall flush (3-stage instance)
        vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'hDEADBEEF_00400004, 1'b0, 64'h0, 0, 0, 0};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'hDEADBEEF_00400004, 1'b0, 64'h0, 0, 0, 0};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h1,    1'b0, 64'h0, 1, 0, 0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h2,    1'b0, 64'h0, 2, 0, 0};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h3,    1'b1, 64'h1, 3, 0, 0};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h99,   1'b1, 64'h1, 3, 1, 0};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h99,   1'b1, 64'h1, 3, 2, 0};
        vec[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h99,   1'b1, 64'h1, 3, 3, 0};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h99,   1'b1, 64'h1, 3, 4, 0};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b1, 64'h2, 2, 4, 0};
        vec[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b1, 64'h3, 1, 4, 0};
        vec[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b0, 64'h0, 0, 4, 0};
        vec[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h4,    1'b0, 64'h0, 1, 4, 0};
        vec[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h5,    1'b0, 64'h0, 2, 4, 0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h6,    1'b1, 64'h4, 3, 4, 0};
        vec[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h7,    1'b0, 64'h0, 0, 4, 1};
        vec[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h8,    1'b0, 64'h0, 0, 5, 1};

        $display("[TB] directed vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vec[i].r, vec[i].e, vec[i].f, vec[i].v, vec[i].d);
            cmp($sformatf("vec%0d.valid_out", i), 64'(validA), 64'(vec[i].expValid));
            cmp($sformatf("vec%0d.data_out", i),  dataA,       vec[i].expData);
            cmp($sformatf("vec%0d.occupancy", i), 64'(occA),   64'(vec[i].expOcc));
            cmp($sformatf("vec%0d.stall", i),     64'(stallA), 64'(vec[i].expStall));
            cmp($sformatf("vec%0d.flush", i),     64'(flushA), 64'(vec[i].expFlush));
            if (i == 1) begin
                cmp("B.reset.valid_out", 64'(validB), 64'h0);
                cmp("B.reset.data_out",  dataB,       64'h0);
                cmp("B.reset.occupancy", 64'(occB),   64'h0);
                cmp("B.reset.stall",     64'(stallB), 64'h0);
                cmp("B.reset.flush",     64'(flushB), 64'h0);
            end
            if (i == 9) begin
                cmp("B.invalid.valid_out", 64'(validB), 64'h0);
                cmp("B.invalid.data_out",  dataB,       64'h1234);
            end
        end

        $display("[TB] randomized traffic against reference model");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 99) >= 3),
                          ($urandom_range(0, 99) < 70),
                          ($urandom_range(0, 99) < 10),
                          ($urandom_range(0, 99) < 70),
                          {$urandom, $urandom});
        end

        $display("[TB] counter saturation");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 64'h55);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h66);
        end
        cmp("sat.B.stall_count", 64'(stallB), 64'd15);
        cmp("sat.A.stall_count", 64'(stallA), 64'd20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
        cmp("sat.B.after_reset", 64'(stallB), 64'd0);
        cmp("sat.A.after_reset", 64'(stallA), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_register.md
Name: pipe_stage_register

Overview:
- Parametrised successor of the fixed IF/ID pipeline register, for use at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) or as a multi-cycle delay line.
- Carries a DATA_WIDTH payload plus a valid bit through NUM_STAGES chained register slices.
- The hazard unit drives a common advance (enable) and a flush that forces bubbles.
- Saturating stall and flush counters provide performance observation.

Parameters:
- DATA_WIDTH, 64, payload width (default packs instruction[31:0] and pc_plus_4[31:0]).
- NUM_STAGES, 1, number of chained slices; legal range 1..8.
- BUBBLE_VALUE, 0, payload value loaded on reset, flush, or invalid capture (0 = MIPS sll $0 nop).
- ZERO_INVALID, 1, 1 = a slice captured with valid 0 stores BUBBLE_VALUE; 0 = stores the payload unchanged.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk, input, 1, sole clock; all state updates on the posedge.
- reset, input, 1, synchronous, active-low; a reset takes effect only at a clk posedge.
- enable, input, 1, 1 = the whole chain advances one slice; 0 = the chain holds (stall).
- flush, input, 1, 1 = every slice becomes a bubble at this edge.
- valid_in, input, 1, stage-0 input is a real operation.
- data_in, input, DATA_WIDTH, stage-0 payload.
- valid_out, output, 1, valid bit of the last slice.
- data_out, output, DATA_WIDTH, payload of the last slice.
- occupancy, output, clog2(NUM_STAGES+1), count of valid slices.
- stall_count, output, CNT_WIDTH, saturating count of stall cycles.
- flush_count, output, CNT_WIDTH, saturating count of flush cycles.

Behaviour:
- Priority at each posedge: reset == 0 > flush == 1 > enable == 1 > hold.
- Reset (reset == 0 at the edge):
  - every slice gets valid = 0 and data = BUBBLE_VALUE;
  - both counters are cleared to 0;
  - therefore valid_out = 0, data_out = BUBBLE_VALUE, occupancy = 0.
  - A reset asserted mid-stream discards all in-flight entries with no drain.
- Flush (reset == 1, flush == 1):
  - every slice gets valid = 0 and data = BUBBLE_VALUE, whatever enable is;
  - valid_in/data_in on that edge are dropped;
  - flush_count increments; stall_count does not.
- Advance (reset == 1, flush == 0, enable == 1):
  - slice[0] captures valid_in and data_in; data is forced to BUBBLE_VALUE when valid_in == 0 and ZERO_INVALID == 1;
  - slice[i] captures slice[i-1] for i = 1..NUM_STAGES-1.
- Stall (reset == 1, flush == 0, enable == 0):
  - all slices hold their contents;
  - stall_count increments.
- Latency: with enable held at 1, an entry captured at edge k appears on data_out after edge k+NUM_STAGES-1, i.e. NUM_STAGES edges to become visible. Each stalled edge adds one cycle.
- Outputs (valid_out, data_out) are direct register outputs with no combinational path from the inputs.
- occupancy is the combinational popcount of the slice valid bits.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- NUM_STAGES == 1 must behave exactly like the legacy IF/ID register, plus the valid bit, flush and counters.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_WORD = 32'h0000_0000;
  - the IF/ID payload packing offsets: INSTR_LSB = 0, PC4_LSB = 32.
- One sub-module, pipe_slice: a single valid+data register with load, bubble and hold controls. It is instantiated NUM_STAGES times via generate.
- The counters stay in the top module.

Test Plan:
- Reset: reset = 0 for 2 cycles with data_in = 0xDEADBEEF_00400004 and valid_in = 1, NUM_STAGES = 1 -> valid_out = 0, data_out = 0, both counters = 0, occupancy = 0.
- Streaming: NUM_STAGES = 3, enable = 1, inject values 1, 2, 3 on consecutive edges -> value 1 appears on data_out after the 3rd edge, then 2 and 3 on following edges; occupancy reads 1, 2, 3.
- Stall: with 3 entries in flight, enable = 0 for 4 cycles -> data_out is constant, stall_count = 4; resuming enable = 1 delivers the remaining entries in order.
- Flush during stall: enable = 0 and flush = 1 for one edge with 3 valid entries -> occupancy = 0, data_out = BUBBLE_VALUE, flush_count = 1, stall_count unchanged.
- Invalid capture: valid_in = 0 with data_in = 0x1234, ZERO_INVALID = 1 -> that slice holds 0. With ZERO_INVALID = 0 -> it holds 0x1234 and valid = 0.
- Saturation: CNT_WIDTH = 4, 20 stall cycles -> stall_count = 15. Then reset = 0 for one edge -> stall_count = 0.
